ct_mat_lsu_row_seq: RTL

- Sequencer for matrix load/store instructions issued on the pipe8 LSU slot.
- Latches one instruction (base, stride, meta) and breaks it into x_sizeM row requests to the matrix memory port.
- Uses a valid/ready handshake; holds busy until the last row is accepted, then pulses done.
- Sits between the IDU pipe8 LSU select and the matrix LSU datapath; takes tile sizes from the config unit's x_sizeM/x_sizeK.

---
 rtl/ct_mat_pkg.sv | 31 +++
 rtl/ct_mat_lsu_row_seq.sv | 113 +++++++++++
 2 files changed

// File: rtl/ct_mat_pkg.sv
// Shared types and constants for the matrix LSU row sequencer.
// Row transfer size, meta bit layout, FSM state encoding and request bundle.
package ct_mat_pkg;

  localparam int MAT_RLEN      = 512;
  localparam int MAT_ADDR_W    = 64;
  localparam int MAT_ROW_BYTES = MAT_RLEN / 8;
  localparam int META_ST_BIT   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } mat_seq_state_e;

  typedef struct packed {
    logic [MAT_ADDR_W-1:0] addr;
    logic [7:0]            row;
    logic [15:0]           bytes;
    logic                  st;
    logic                  last;
    logic [15:0]           meta;
  } mat_lsu_req_t;

  // Bytes moved per row: the configured K, capped at one full row register.
  function automatic logic [15:0] row_bytes(input logic [15:0] k, input int unsigned max_b);
    if (32'(k) > max_b) return max_b[15:0];
    return k;
  endfunction

endpackage

// File: rtl/ct_mat_lsu_row_seq.sv
// Splits one matrix load/store into x_sizeM row requests; first request 1 cycle after sel, 1 row/cycle.
// Requests hold stable while mat_lsu_req_rdy is low; done pulses one cycle after the last row is accepted.
module ct_mat_lsu_row_seq
  import ct_mat_pkg::*;
#(
  parameter int RLEN   = MAT_RLEN,
  parameter int ADDR_W = MAT_ADDR_W
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              idu_mat_rf_lsu_sel,
  input  logic [15:0]       idu_mat_rf_pipe8_lsu_meta,
  input  logic [ADDR_W-1:0] idu_mat_rf_pipe8_lsu_src0,
  input  logic              idu_mat_rf_pipe8_lsu_src1_vld,
  input  logic [ADDR_W-1:0] idu_mat_rf_pipe8_lsu_src1,
  input  logic [7:0]        x_sizeM,
  input  logic [15:0]       x_sizeK,
  input  logic              mat_flush,
  input  logic              mat_lsu_req_rdy,
  output logic              mat_lsu_req_vld,
  output logic [ADDR_W-1:0] mat_lsu_req_addr,
  output logic [7:0]        mat_lsu_req_row,
  output logic [15:0]       mat_lsu_req_bytes,
  output logic              mat_lsu_req_st,
  output logic              mat_lsu_req_last,
  output logic [15:0]       mat_lsu_req_meta,
  output logic              mat_lsu_busy,
  output logic              mat_lsu_done
);

  localparam int ROW_BYTES = RLEN / 8;

  mat_seq_state_e    state_q, state_d;
  mat_lsu_req_t      req_q, req_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [7:0]        m_q, m_d;
  logic [15:0]       bytes_c;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    stride_d = stride_q;
    m_d      = m_q;
    bytes_c  = row_bytes(x_sizeK, ROW_BYTES);

    // Flush wins over everything: no latch, no advance, straight back to IDLE.
    if (mat_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (idu_mat_rf_lsu_sel) begin
            req_d.addr  = idu_mat_rf_pipe8_lsu_src0;
            req_d.row   = 8'd0;
            req_d.bytes = bytes_c;
            req_d.st    = idu_mat_rf_pipe8_lsu_meta[META_ST_BIT];
            req_d.last  = (x_sizeM == 8'd1);
            req_d.meta  = idu_mat_rf_pipe8_lsu_meta;
            m_d         = x_sizeM;
            stride_d    = idu_mat_rf_pipe8_lsu_src1_vld ? idu_mat_rf_pipe8_lsu_src1
                                                        : ADDR_W'(bytes_c);
            state_d     = (x_sizeM != 8'd0) ? ST_ISSUE : ST_DONE;
          end
        end
        ST_ISSUE: begin
          if (mat_lsu_req_rdy) begin
            if (req_q.last) begin
              state_d = ST_DONE;
            end else begin
              req_d.addr = req_q.addr + stride_q;
              req_d.row  = req_q.row + 8'd1;
              // Not last here, so row <= M-2 and row+2 cannot overflow 8 bits.
              req_d.last = ((req_q.row + 8'd2) == m_q);
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      stride_q <= '0;
      m_q      <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      stride_q <= stride_d;
      m_q      <= m_d;
    end
  end

  assign mat_lsu_req_vld   = (state_q == ST_ISSUE);
  assign mat_lsu_req_addr  = req_q.addr;
  assign mat_lsu_req_row   = req_q.row;
  assign mat_lsu_req_bytes = req_q.bytes;
  assign mat_lsu_req_st    = req_q.st;
  assign mat_lsu_req_last  = req_q.last;
  assign mat_lsu_req_meta  = req_q.meta;
  assign mat_lsu_busy      = (state_q != ST_IDLE);
  assign mat_lsu_done      = (state_q == ST_DONE);

  // The IDU may only start an instruction while the sequencer is idle.
  sel_only_when_idle: assert property (
    @(posedge forever_cpuclk) disable iff (!cpurst_b)
      idu_mat_rf_lsu_sel |-> (state_q == ST_IDLE)
  );

endmodule
